// File: rtl/tanh_act_pkg.sv
// Shared types and constants for the 4-bit approximate tanh datapath:
// Q2.2 magnitude code plus sign/saturation side-band.
package tanh_act_pkg;

  localparam int          CODE_W    = 4;
  localparam logic [3:0]  CODE_MAX  = 4'd15;
  localparam int          CODE_FRAC = 2;

  typedef logic [CODE_W-1:0] code_t;

  typedef struct packed {
    code_t code;
    logic  sign;
    logic  sat;
  } act_code_t;

  // Clamp a wide unsigned rounded magnitude to the code range.
  function automatic code_t sat_code(input logic [32:0] r);
    if (r > 33'(CODE_MAX)) begin
      sat_code = CODE_MAX;
    end else begin
      sat_code = r[CODE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/act_pipe_reg.sv
// Single valid/ready register slice; payload and valid are registered,
// ready is passed back combinationally so a full slice can still stream.
module act_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic         load;

  assign in_ready  = ~valid_q | out_ready;
  assign load      = in_valid & in_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next-state: load a new word, drain on downstream accept, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/tanh_in_quant_4bit.sv
// Accumulator-to-Q2.2 quantiser feeding the 4-bit tanh block (2-stage pipe).
// Optional saturation counter enabled by macro TANH_IN_QUANT_SATCNT_EN.
module tanh_in_quant_4bit
  import tanh_act_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int SHIFT = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [ACC_W-1:0] s_acc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [3:0]       m_code,
  output logic             m_sign,
  output logic             m_sat
`ifdef TANH_IN_QUANT_SATCNT_EN
  ,
  output logic [15:0]      sat_cnt,
  input  logic             sat_cnt_clr
`endif
);

  localparam int S1_W   = ACC_W + 2;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] RND =
    (SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RND_SH) : {(ACC_W+1){1'b0}};

  logic [ACC_W:0]   acc_ext;
  logic [ACC_W:0]   mag_in;
  logic [S1_W-1:0]  s1_in;
  logic [S1_W-1:0]  s1_out;
  logic             s1_valid;
  logic             s2_ready;
  logic [ACC_W:0]   rnd_sum;
  logic [ACC_W:0]   r_val;
  act_code_t        s2_in;
  act_code_t        s2_out;

  // Sign/magnitude split; one extra bit so the most negative input stays positive.
  always_comb begin
    acc_ext = {s_acc[ACC_W-1], s_acc};
    if (s_acc[ACC_W-1]) begin
      mag_in = ~acc_ext + {{ACC_W{1'b0}}, 1'b1};
    end else begin
      mag_in = acc_ext;
    end
    s1_in = {s_acc[ACC_W-1], mag_in};
  end

  act_pipe_reg #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_out)
  );

  // Round half away from zero on the magnitude, then clamp to the code range.
  always_comb begin
    rnd_sum    = s1_out[ACC_W:0] + RND;
    r_val      = rnd_sum >> SHIFT;
    s2_in.sat  = (r_val > (ACC_W+1)'(CODE_MAX));
    s2_in.code = sat_code(33'(r_val));
    s2_in.sign = s1_out[S1_W-1] & (s2_in.code != 4'd0);
  end

  act_pipe_reg #(.W($bits(act_code_t))) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (s2_out)
  );

  assign m_code = s2_out.code;
  assign m_sign = s2_out.sign;
  assign m_sat  = s2_out.sat;

`ifdef TANH_IN_QUANT_SATCNT_EN
  logic [15:0] sat_cnt_q;
  logic [15:0] sat_cnt_d;

  // Count clipped words leaving the stage; clear has priority, sticks at max.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_cnt_clr) begin
      sat_cnt_d = 16'd0;
    end else if (m_valid & m_ready & m_sat & (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= 16'd0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_tanh_in_quant_4bit.sv
// Scoreboard bench for tanh_in_quant_4bit (ACC_W=16, SHIFT=6); exercises the
// sat counter too when TANH_IN_QUANT_SATCNT_EN is defined.
module tb_tanh_in_quant_4bit;

  localparam int ACC_W = 16;
  localparam int SHIFT = 6;

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [ACC_W-1:0] s_acc;
  logic             m_valid;
  logic             m_ready;
  logic [3:0]       m_code;
  logic             m_sign;
  logic             m_sat;
`ifdef TANH_IN_QUANT_SATCNT_EN
  logic [15:0]      sat_cnt;
  logic             sat_cnt_clr;
`endif

  int total;
  int bad;
  logic [5:0] sb[$];
  bit         rand_rdy;
  int         low_run;
  bit         hold_chk;
  logic [3:0] h_code;
  logic       h_sign;
  logic       h_sat;
  int         exp_cnt;

  tanh_in_quant_4bit #(.ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_acc   (s_acc),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_code  (m_code),
    .m_sign  (m_sign),
    .m_sat   (m_sat)
`ifdef TANH_IN_QUANT_SATCNT_EN
    ,
    .sat_cnt     (sat_cnt),
    .sat_cnt_clr (sat_cnt_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: {code[3:0], sign, sat}
  function automatic logic [5:0] model(input logic [15:0] a);
    int v, m, r, code;
    logic sg, st;
    v    = int'($signed(a));
    m    = (v < 0) ? -v : v;
    r    = (m + (1 << (SHIFT - 1))) / (1 << SHIFT);
    st   = (r > 15);
    code = st ? 15 : r;
    sg   = (v < 0) && (code != 0);
    return {code[3:0], sg, st};
  endfunction

  task automatic cyc(output bit acc);
    logic [5:0] e;
    if (rand_rdy) begin
      if (low_run > 0) begin
        m_ready = 1'b0;
        low_run--;
      end else begin
        m_ready = 1'($urandom_range(0, 1));
      end
    end
    #1;
    acc = s_valid && s_ready;
    if (hold_chk) begin
      chk("hold_valid", {31'd0, m_valid}, 32'd1);
      chk("hold_code", {28'd0, m_code}, {28'd0, h_code});
      chk("hold_sign", {31'd0, m_sign}, {31'd0, h_sign});
      chk("hold_sat", {31'd0, m_sat}, {31'd0, h_sat});
    end
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", {31'd0, m_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("code", {28'd0, m_code}, {28'd0, e[5:2]});
        chk("sign", {31'd0, m_sign}, {31'd0, e[1]});
        chk("sat", {31'd0, m_sat}, {31'd0, e[0]});
        if (e[0] && exp_cnt < 65535) exp_cnt++;
      end
    end
    hold_chk = m_valid && !m_ready;
    h_code   = m_code;
    h_sign   = m_sign;
    h_sat    = m_sat;
    if (acc) sb.push_back(model(s_acc));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] v);
    bit a;
    a       = 1'b0;
    s_acc   = v;
    s_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc(a);
      if (a) break;
    end
    if (!a) chk("send_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
    s_acc   = 16'($urandom);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(a);
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 80 && sb.size() != 0; i++) cyc(a);
    chk("drain_left", sb.size(), 32'd0);
  endtask

  initial begin
    logic [15:0] vec [10];
    total    = 0;
    bad      = 0;
    rand_rdy = 1'b0;
    low_run  = 0;
    hold_chk = 1'b0;
    exp_cnt  = 0;
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_acc    = 16'd0;
    m_ready  = 1'b0;
`ifdef TANH_IN_QUANT_SATCNT_EN
    sat_cnt_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_code", {28'd0, m_code}, 32'd0);
    chk("rst_m_sign", {31'd0, m_sign}, 32'd0);
    chk("rst_m_sat", {31'd0, m_sat}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: 2 cycles with no backpressure.
    m_ready = 1'b1;
    send(16'h0100);
    chk("lat1_valid", {31'd0, m_valid}, 32'd0);
    idle(1);
    chk("lat2_valid", {31'd0, m_valid}, 32'd1);
    drain();

    // Directed rounding / sign / saturation boundaries, back to back.
    vec = '{16'h0120, 16'h011F, 16'hFF00, 16'hFFE1, 16'hFFE0,
            16'h7FFF, 16'h8000, 16'h03DF, 16'h03E0, 16'h0000};
    foreach (vec[i]) send(vec[i]);
    drain();

    // Fill both stages under backpressure; ready must drop and outputs hold.
    m_ready = 1'b0;
    send(16'h0040);
    send(16'hFFC0);
    s_valid = 1'b1;
    s_acc   = 16'h0200;
    #1;
    chk("full_s_ready", {31'd0, s_ready}, 32'd0);
    idle(3);
    s_valid = 1'b0;
    m_ready = 1'b1;
    drain();

    // Random stream with random ready, including a forced 5-cycle stall.
    rand_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) low_run = 5;
      send(16'($urandom));
    end
    drain();
    rand_rdy = 1'b0;
    m_ready  = 1'b1;

    // Reset with two words in flight.
    m_ready = 1'b0;
    send(16'h0300);
    send(16'h7000);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    sb.delete();
    hold_chk = 1'b0;
    exp_cnt  = 0;
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("post_rst_idle", {31'd0, m_valid}, 32'd0);
    end
    send(16'hFF40);
    drain();

`ifdef TANH_IN_QUANT_SATCNT_EN
    sat_cnt_clr = 1'b1;
    idle(1);
    sat_cnt_clr = 1'b0;
    exp_cnt = 0;
    chk("cnt_cleared", {16'd0, sat_cnt}, 32'd0);
    send(16'h7FFF);
    send(16'h8000);
    send(16'h0100);
    send(16'h03E0);
    drain();
    idle(1);
    chk("cnt_three", {16'd0, sat_cnt}, exp_cnt);
    sat_cnt_clr = 1'b1;
    idle(1);
    sat_cnt_clr = 1'b0;
    chk("cnt_clr", {16'd0, sat_cnt}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tanh_in_quant_4bit.md
Name: tanh_in_quant_4bit

Overview:
- Upstream feeder stage for the 4-bit approximate tanh circuits.
- Takes a signed fixed-point accumulator word from the MAC and splits it into sign and magnitude.
- Rounds and shifts the magnitude into the 4-bit Q2.2 code, range [0, 3.75], step 0.25.
- Saturates that code, then delivers code plus sign over a 2-deep valid/ready pipeline. The downstream tanh block consumes the code; the sign is carried alongside so the consumer can restore odd symmetry.

Parameters:
- ACC_W, 16, width of the signed accumulator input (two's complement), legal 8..32.
- SHIFT, 6, right-shift from the accumulator fraction to 2 fractional bits (Q8.8 -> Q2.2), legal 0..ACC_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  stage can accept input
- s_acc  in  ACC_W  signed accumulator value
- m_valid  out  1  output code valid
- m_ready  in  1  downstream accepts output
- m_code  out  4  saturated magnitude code, feeds the tanh block's In[3:0]
- m_sign  out  1  1 = negative input
- m_sat  out  1  1 = magnitude was clipped to 15

Behaviour:
- Reset: asynchronous on rst_n low. Both stage valids clear, m_valid=0, m_code=0, m_sign=0, m_sat=0. Register contents are don't-care except the listed outputs.
- Transfer rules:
  - Input transfer occurs when s_valid & s_ready.
  - Output transfer occurs when m_valid & m_ready.
- Stage 1 (S1) registers:
  - sign = s_acc[ACC_W-1].
  - mag = |s_acc|, computed in ACC_W+1 bits so that -2^(ACC_W-1) gives +2^(ACC_W-1) without overflow.
- Stage 2 (S2) registers:
  - r = (mag + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT, computed in ACC_W+1 bits. This is round-half-away-from-zero on the signed value.
  - m_code = min(r, 15).
  - m_sat = (r > 15).
  - m_sign = sign & (m_code != 0), so no negative zero is produced.
- Latency: 2 cycles from input transfer to m_valid with no backpressure. Throughput is 1 word/cycle.
- Flow control: standard pipeline, no combinational path from s_valid to m_valid.
  - S2 loads when S1 is valid and (S2 is empty or m_ready).
  - S1 loads on input transfer.
  - s_ready = ~v1 | (~v2 | m_ready). This is the only combinational ready path.
- Stall: while m_valid & ~m_ready, m_code/m_sign/m_sat hold stable. At most 2 words are held internally; no word is dropped or duplicated.
- Simultaneous accept and emit in one cycle is legal and keeps full throughput.
- s_acc is sampled only on input transfer; changes while not accepted are ignored.
- Reset mid-operation discards in-flight words. The first valid output after rst_n rises comes from the first accepted post-reset input.

Optional Feature:
- Macro TANH_IN_QUANT_SATCNT_EN.
- Defined: adds output port sat_cnt (16 bits) and input port sat_cnt_clr (1 bit).
  - sat_cnt increments by 1 on each output transfer with m_sat=1.
  - It saturates at 0xFFFF.
  - sat_cnt_clr zeroes it synchronously and wins over a same-cycle increment.
  - It resets to 0 on rst_n.
- Undefined: neither port exists and the datapath behaviour is identical.

Decomposition:
- Shared package tanh_act_pkg holds:
  - CODE_W=4, CODE_MAX=4'd15, CODE_FRAC=2.
  - Typedef for the code, and a struct {code, sign, sat} shared with the downstream tanh wrapper.
- One natural sub-module, act_pipe_reg: a single valid/ready register slice parameterised on payload width, instantiated twice (S1, S2).

Test Plan:
- s_acc=0x0100 (1.0), m_ready=1 -> after 2 cycles m_code=4, m_sign=0, m_sat=0.
- s_acc=0x0120 (1.125) -> m_code=5 (rounds half up). s_acc=0x011F -> m_code=4.
- s_acc=-256 -> m_code=4, m_sign=1. s_acc=-31 -> m_code=0, m_sign=0 (no negative zero). s_acc=-32 -> m_code=1, m_sign=1.
- Saturation:
  - s_acc=0x7FFF -> m_code=15, m_sat=1.
  - s_acc=0x8000 -> m_code=15, m_sign=1, m_sat=1.
  - s_acc=0x03DF -> m_code=15, m_sat=0. s_acc=0x03E0 -> m_code=15, m_sat=1.
- Backpressure:
  - Stream 10 values with m_ready toggled randomly (including 5 low cycles in a row); output order and values match the model.
  - s_ready goes 0 after 2 words are held; outputs stay stable during the stall.
- Reset and counter:
  - Assert rst_n low with 2 words in flight -> m_valid=0 immediately; no stale word appears after release.
  - With the macro defined, 3 saturating words -> sat_cnt=3; sat_cnt_clr -> 0.
